// File: rtl/sprite_loader_if.sv
// Sprite loader connection bundle: load request, byte stream in, engine register write bus out.
// master is the feeding side, slave is the loader itself.
`timescale 1ns/1ps
interface sprite_loader_if;
    logic        start;
    logic        sprite_sel;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        eng_enabled;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_n;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, sprite_sel, in_valid, in_data, eng_enabled,
        input  in_ready, wr_addr, wr_data, wr_n, busy, done, err
    );

    modport slave (
        input  start, sprite_sel, in_valid, in_data, eng_enabled,
        output in_ready, wr_addr, wr_data, wr_n, busy, done, err
    );
endinterface

// File: rtl/sprite_loader.sv
// Streams a 20-byte sprite record (X, Y, 18 bitmap bytes) into the sprite engine as ten
// little-endian 16-bit register writes, with a per-byte inactivity timeout.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start
// S_LO    | waiting for low byte of word k
// S_HI    | waiting for high byte of word k
// S_WRITE | word k on the bus; strobed once the engine stream is disabled
// S_DONE  | one-cycle completion pulse
`timescale 1ns/1ps
module sprite_loader #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    sprite_loader_if.slave  lif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_WRITE,
        S_DONE
    } state_t;

    localparam int                CNT_W    = 10;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]        K_LAST   = 4'd9;
    localparam logic [5:0]        BASE_S0  = 6'h04;
    localparam logic [5:0]        BASE_S1  = 6'h1A;

    state_t             state_q, state_d;
    logic [3:0]         k_q, k_d;
    logic               sel_q, sel_d;
    logic [7:0]         lo_q, lo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]         wr_addr_q, wr_addr_d;
    logic [15:0]        wr_data_q, wr_data_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               xfer;
    logic               timed_out;
    logic [5:0]         word_addr;

    assign xfer      = lif.in_valid && in_ready_q;
    assign timed_out = (cnt_q == CNT_LAST);
    assign word_addr = (sel_q ? BASE_S1 : BASE_S0) + {1'b0, k_q, 1'b0};

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        sel_d     = sel_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (lif.start) begin
                    sel_d   = lif.sprite_sel;
                    k_d     = 4'd0;
                    cnt_d   = '0;
                    state_d = S_LO;
                end
            end
            S_LO, S_HI: begin
                if (xfer) begin
                    cnt_d = '0;
                    if (state_q == S_LO) begin
                        lo_d    = lif.in_data;
                        state_d = S_HI;
                    end else begin
                        wr_addr_d = word_addr;
                        wr_data_d = {lif.in_data, lo_q};
                        state_d   = S_WRITE;
                    end
                end else if (timed_out) begin
                    // Abort without rollback; words already strobed stay in the engine.
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WRITE: begin
                // No timeout here: the engine may hold the stream enabled indefinitely.
                if (!lif.eng_enabled) begin
                    if (k_q == K_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        cnt_d   = '0;
                        state_d = S_LO;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_LO) || (state_d == S_HI);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            k_q        <= 4'd0;
            sel_q      <= 1'b0;
            lo_q       <= 8'h00;
            cnt_q      <= '0;
            wr_addr_q  <= 6'h00;
            wr_data_q  <= 16'h0000;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            sel_q      <= sel_d;
            lo_q       <= lo_d;
            cnt_q      <= cnt_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // The strobe must follow eng_enabled in the same cycle so the engine never drops a write.
    assign lif.wr_n     = (state_q == S_WRITE && !lif.eng_enabled && !rst) ? 2'b01 : 2'b11;
    assign lif.wr_addr  = wr_addr_q;
    assign lif.wr_data  = wr_data_q;
    assign lif.in_ready = in_ready_q;
    assign lif.busy     = busy_q;
    assign lif.done     = done_q;
    assign lif.err      = err_q;

endmodule

// File: tb/tb_sprite_loader.sv
// Scoreboard bench for sprite_loader: stimulus queues the expected write/done/err events,
// a negedge monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_sprite_loader;

    localparam int         TMO   = 8;
    localparam logic [5:0] BASE0 = 6'h04;
    localparam logic [5:0] BASE1 = 6'h1A;

    typedef struct {
        int          kind;   // 0 write, 1 done, 2 err
        logic [5:0]  addr;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sprite_loader_if lif();

    sprite_loader #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .lif (lif)
    );

    int        compared   = 0;
    int        mismatched = 0;
    exp_t      sb[$];
    logic [7:0] bytes[20];
    bit        rand_stall = 1'b0;

    int        cyc         = 0;
    int        last_wr_cyc = -10;
    bit        par         = 1'b0;
    bit        pending     = 1'b0;
    exp_t      mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_stall) lif.eng_enabled = ($urandom_range(0, 2) == 0);
    endtask

    // Expected events from the record layout: word k = {byte 2k+1, byte 2k} at base + 2k.
    task automatic push_expect(input bit sel, input int nsend, input int endkind);
        exp_t e;
        for (int k = 0; k < nsend / 2; k++) begin
            e.kind = 0;
            e.addr = (sel ? BASE1 : BASE0) + 6'(2 * k);
            e.data = {bytes[2*k+1], bytes[2*k]};
            sb.push_back(e);
        end
        if (endkind != 0) begin
            e.kind = endkind;
            e.addr = 6'h00;
            e.data = 16'h0000;
            sb.push_back(e);
        end
    endtask

    task automatic start_load(input bit sel);
        lif.sprite_sel = sel;
        lif.start      = 1'b1;
        tick();
        lif.start      = 1'b0;
        lif.sprite_sel = 1'($urandom_range(0, 1));
        chk("start_busy", 32'(lif.busy), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok           = 1'b0;
        lif.in_valid = 1'b1;
        lif.in_data  = b;
        for (int i = 0; i < 300; i++) begin
            if (lif.in_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        lif.in_valid = 1'b0;
        if (!ok) fail_now("byte_accept_timeout");
    endtask

    task automatic send_bytes(input int from, input int to, input bit gaps, input bit pokes, input bit sel);
        for (int i = from; i < to; i++) begin
            if (gaps) repeat ($urandom_range(0, 5)) tick();
            if (pokes && $urandom_range(0, 7) == 0) begin
                lif.start      = 1'b1;
                lif.sprite_sel = ~sel;
                tick();
                lif.start      = 1'b0;
            end
            send_byte(bytes[i]);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && lif.busy; i++) tick();
        if (lif.busy) fail_now("idle_timeout");
        tick();
        chk("sb_drain", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic fill_directed();
        bytes[0] = 8'h10;
        bytes[1] = 8'h20;
        for (int i = 2; i < 20; i++) bytes[i] = 8'(i - 1);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 20; i++) bytes[i] = 8'($urandom);
    endtask

    // Monitor: the loader must strobe in the first cycle after a high byte in which the
    // engine stream is disabled, and every strobe/done/err must match the queue head.
    always @(negedge clk) begin
        cyc++;
        if (lif.wr_n != 2'b11 && lif.wr_n != 2'b01) chk("wr_n_legal", 32'(lif.wr_n), 32'h3);
        if (rst) begin
            par     = 1'b0;
            pending = 1'b0;
        end else begin
            if (pending && !lif.eng_enabled) begin
                chk("wr_latency", 32'(lif.wr_n), 32'h1);
                pending = 1'b0;
            end else if (pending) begin
                chk("stall_wr_n", 32'(lif.wr_n), 32'h3);
                chk("stall_in_ready", 32'(lif.in_ready), 32'd0);
            end else if (lif.wr_n == 2'b01) begin
                chk("spurious_write", 32'(lif.wr_n), 32'h3);
            end

            if (lif.wr_n == 2'b01) begin
                if (sb.size() == 0) fail_now("unexpected_write");
                else begin
                    mon_e = sb.pop_front();
                    chk("wr_kind", 32'(mon_e.kind), 32'd0);
                    chk("wr_addr", 32'(lif.wr_addr), 32'(mon_e.addr));
                    chk("wr_data", 32'(lif.wr_data), 32'(mon_e.data));
                end
                last_wr_cyc = cyc;
            end
            if (lif.done) begin
                if (sb.size() == 0) fail_now("unexpected_done");
                else begin
                    mon_e = sb.pop_front();
                    chk("done_kind", 32'(mon_e.kind), 32'd1);
                end
                chk("done_timing", 32'(cyc), 32'(last_wr_cyc + 1));
                chk("done_busy", 32'(lif.busy), 32'd1);
            end
            if (lif.err) begin
                if (sb.size() == 0) fail_now("unexpected_err");
                else begin
                    mon_e = sb.pop_front();
                    chk("err_kind", 32'(mon_e.kind), 32'd2);
                end
                chk("err_busy", 32'(lif.busy), 32'd0);
                par     = 1'b0;
                pending = 1'b0;
            end
            if (lif.in_valid && lif.in_ready) begin
                par = ~par;
                if (!par) pending = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  err_at;
        bit  sel;
        int  nsend;

        lif.start       = 1'b0;
        lif.sprite_sel  = 1'b0;
        lif.in_valid    = 1'b0;
        lif.in_data     = 8'h00;
        lif.eng_enabled = 1'b0;
        rst             = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        chk("rst_in_ready", 32'(lif.in_ready), 32'd0);
        chk("rst_busy",     32'(lif.busy),     32'd0);
        chk("rst_done",     32'(lif.done),     32'd0);
        chk("rst_err",      32'(lif.err),      32'd0);
        chk("rst_wr_n",     32'(lif.wr_n),     32'h3);
        chk("rst_wr_addr",  32'(lif.wr_addr),  32'h0);
        chk("rst_wr_data",  32'(lif.wr_data),  32'h0);
        tick();

        // Reference stream, sprite 0 then sprite 1, back-to-back bytes.
        fill_directed();
        for (int s = 0; s < 2; s++) begin
            push_expect(1'(s), 20, 1);
            start_load(1'(s));
            send_bytes(0, 20, 1'b0, 1'b0, 1'(s));
            wait_idle();
        end

        // Start pokes with the other sprite_sel mid-load are ignored.
        fill_random();
        push_expect(1'b0, 20, 1);
        start_load(1'b0);
        send_bytes(0, 9, 1'b0, 1'b0, 1'b0);
        lif.start      = 1'b1;
        lif.sprite_sel = 1'b1;
        tick();
        lif.start      = 1'b0;
        send_bytes(9, 20, 1'b0, 1'b1, 1'b0);
        wait_idle();

        // Engine stream held enabled over word 3 for 50 cycles.
        fill_random();
        push_expect(1'b0, 20, 1);
        start_load(1'b0);
        send_bytes(0, 7, 1'b0, 1'b0, 1'b0);
        lif.eng_enabled = 1'b1;
        send_byte(bytes[7]);
        for (int i = 0; i < 50; i++) begin
            chk("stall_ready_d", 32'(lif.in_ready), 32'd0);
            chk("stall_wr_n_d",  32'(lif.wr_n),     32'h3);
            chk("stall_addr",    32'(lif.wr_addr),  32'h0A);
            chk("stall_data",    32'(lif.wr_data),  32'({bytes[7], bytes[6]}));
            chk("stall_err",     32'(lif.err),      32'd0);
            tick();
        end
        lif.eng_enabled = 1'b0;
        send_bytes(8, 20, 1'b0, 1'b0, 1'b0);
        wait_idle();

        // Timeout after five bytes: two writes, then err after TMO idle cycles.
        fill_random();
        push_expect(1'b1, 5, 2);
        start_load(1'b1);
        send_bytes(0, 5, 1'b0, 1'b0, 1'b1);
        err_at = -1;
        for (int i = 1; i <= 30; i++) begin
            if (lif.err) begin
                err_at = i;
                break;
            end
            tick();
        end
        chk("err_cycle", 32'(err_at), 32'(TMO + 1));
        chk("err_busy_low", 32'(lif.busy), 32'd0);
        wait_idle();

        // Reset while waiting for the high byte of word 3.
        fill_random();
        push_expect(1'b0, 7, 0);
        start_load(1'b0);
        send_bytes(0, 7, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_wr_n",     32'(lif.wr_n),     32'h3);
        chk("mrst_busy",     32'(lif.busy),     32'd0);
        chk("mrst_in_ready", 32'(lif.in_ready), 32'd0);
        chk("mrst_wr_addr",  32'(lif.wr_addr),  32'h0);
        chk("mrst_wr_data",  32'(lif.wr_data),  32'h0);
        wait_idle();
        fill_random();
        push_expect(1'b1, 20, 1);
        start_load(1'b1);
        send_bytes(0, 20, 1'b0, 1'b0, 1'b1);
        wait_idle();

        // Randomized loads: gaps, engine stalls, stray starts, occasional truncation.
        for (int n = 0; n < 12; n++) begin
            sel   = 1'($urandom_range(0, 1));
            fill_random();
            nsend = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 19)) : 20;
            push_expect(sel, nsend, (nsend == 20) ? 1 : 2);
            start_load(sel);
            rand_stall = 1'b1;
            send_bytes(0, nsend, 1'b1, 1'b1, sel);
            wait_idle();
            rand_stall      = 1'b0;
            lif.eng_enabled = 1'b0;
            tick();
        end

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
